// File: rtl/qsys_system_nios2_1_cpu_ocimem_arbiter.sv
// OCI debug RAM arbiter: shares the single 256x32 RAM port between the JTAG
// debug-slave command path and the CPU Avalon debug-memory slave.
// Owns the JTAG address pointer and the MonDReg readback register.
// Optional: define QSYS_NIOS2_OCIMEM_AUTOINC_EN to post-increment the pointer
// after each ocimem_b write and each take_no_action_ocimem_a read.
module qsys_system_nios2_1_cpu_ocimem_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  input  logic [37:0] jdo,
  input  logic        debugack,
  input  logic [7:0]  cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_writedata,
  output logic [31:0] cpu_readdata,
  output logic        cpu_waitrequest,
  output logic        ram_en,
  output logic        ram_wr,
  output logic [7:0]  ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic [31:0] MonDReg,
  output logic        jtag_busy,
  output logic        jtag_overrun
);

  typedef enum logic [2:0] {StIdle, StJtagAcc, StJtagRdw, StCpuAcc, StCpuRdw} state_e;

  state_e      state_q;
  logic        slot_valid_q;
  logic        slot_wr_q;
  logic [7:0]  slot_addr_q;
  logic [31:0] slot_data_q;
  logic [7:0]  ptr_q, ptr_d;
  logic [31:0] mon_q;
  logic        last_jtag_q;
  logic        overrun_q;
  logic        ram_en_q, ram_wr_q;
  logic [7:0]  ram_addr_q;
  logic [31:0] ram_wdata_q;
  logic        waitreq_q;

  logic jtag_inflight, cpu_req, grant_jtag, grant_cpu;
  logic acc_pulse, slot_free, accept, drop;
  logic pulse_wr;
  logic [7:0] pulse_addr;

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[9:0], jdo[2:0]};

  // Arbitration, slot acceptance and pointer next-state
  always_comb begin
    jtag_inflight = (state_q == StJtagAcc) || (state_q == StJtagRdw);
    cpu_req       = cpu_read | cpu_write;
    // Round-robin: JTAG loses contention only if it was granted last and CPU is not halted
    grant_jtag    = (state_q == StIdle) && slot_valid_q &&
                    (!cpu_req || debugack || !last_jtag_q);
    grant_cpu     = (state_q == StIdle) && cpu_req && !grant_jtag;
    acc_pulse     = take_action_ocimem_b | take_no_action_ocimem_a |
                    (take_action_ocimem_a & jdo[35]);
    // A slot draining this cycle can take a new pulse
    slot_free     = (!slot_valid_q || grant_jtag) && !jtag_inflight;
    accept        = acc_pulse && slot_free;
    drop          = acc_pulse && !slot_free;
    pulse_wr      = !take_action_ocimem_a && take_action_ocimem_b;
    pulse_addr    = take_action_ocimem_a ? jdo[17:10] : ptr_q;

    ptr_d = ptr_q;
    if (take_action_ocimem_a) begin
      // Pointer-only loads always apply; a dropped read leaves the pointer alone
      if (!jdo[35] || accept) ptr_d = jdo[17:10];
    end
`ifdef QSYS_NIOS2_OCIMEM_AUTOINC_EN
    else if (accept) begin
      ptr_d = ptr_q + 8'd1;
    end
`endif
  end

  // FSM, RAM port, pending slot and status registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      slot_valid_q <= 1'b0;
      slot_wr_q    <= 1'b0;
      slot_addr_q  <= 8'h00;
      slot_data_q  <= 32'h0;
      ptr_q        <= 8'h00;
      mon_q        <= 32'h0;
      last_jtag_q  <= 1'b0;
      overrun_q    <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_wr_q     <= 1'b0;
      ram_addr_q   <= 8'h00;
      ram_wdata_q  <= 32'h0;
      waitreq_q    <= 1'b1;
    end else begin
      ptr_q     <= ptr_d;
      ram_en_q  <= 1'b0;
      ram_wr_q  <= 1'b0;
      waitreq_q <= 1'b1;
      if (drop) overrun_q <= 1'b1;

      if (accept) begin
        slot_valid_q <= 1'b1;
        slot_wr_q    <= pulse_wr;
        slot_addr_q  <= pulse_addr;
        slot_data_q  <= jdo[34:3];
      end else if (grant_jtag) begin
        slot_valid_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (grant_jtag) begin
            state_q     <= StJtagAcc;
            ram_en_q    <= 1'b1;
            ram_wr_q    <= slot_wr_q;
            ram_addr_q  <= slot_addr_q;
            ram_wdata_q <= slot_data_q;
            last_jtag_q <= 1'b1;
          end else if (grant_cpu) begin
            state_q     <= StCpuAcc;
            ram_en_q    <= 1'b1;
            ram_wr_q    <= cpu_write;
            ram_addr_q  <= cpu_address;
            ram_wdata_q <= cpu_writedata;
            last_jtag_q <= 1'b0;
            waitreq_q   <= !cpu_write;
          end
        end
        // ram_wr_q is high exactly during a write access cycle
        StJtagAcc: state_q <= ram_wr_q ? StIdle : StJtagRdw;
        StJtagRdw: begin
          mon_q   <= ram_rdata;
          state_q <= StIdle;
        end
        StCpuAcc: begin
          if (ram_wr_q) begin
            state_q <= StIdle;
          end else begin
            state_q   <= StCpuRdw;
            waitreq_q <= 1'b0;
          end
        end
        StCpuRdw: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign cpu_readdata    = (state_q == StCpuRdw) ? ram_rdata : 32'h0;
  assign cpu_waitrequest = waitreq_q;
  assign ram_en          = ram_en_q;
  assign ram_wr          = ram_wr_q;
  assign ram_addr        = ram_addr_q;
  assign ram_wdata       = ram_wdata_q;
  assign MonDReg         = mon_q;
  assign jtag_busy       = slot_valid_q | jtag_inflight;
  assign jtag_overrun    = overrun_q;

endmodule

// File: tb/tb_qsys_system_nios2_1_cpu_ocimem_arbiter.sv
// Directed bench for the OCI RAM arbiter with a behavioural 1-cycle RAM.
module tb_qsys_system_nios2_1_cpu_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [37:0] jdo;
  logic        debugack;
  logic [7:0]  cpu_address;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_writedata, cpu_readdata;
  logic        cpu_waitrequest;
  logic        ram_en, ram_wr;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [31:0] MonDReg;
  logic        jtag_busy, jtag_overrun;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  logic [31:0] exp2;

  always #5 clk = ~clk;

  qsys_system_nios2_1_cpu_ocimem_arbiter dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .jdo                     (jdo),
    .debugack                (debugack),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_write               (cpu_write),
    .cpu_writedata           (cpu_writedata),
    .cpu_readdata            (cpu_readdata),
    .cpu_waitrequest         (cpu_waitrequest),
    .ram_en                  (ram_en),
    .ram_wr                  (ram_wr),
    .ram_addr                (ram_addr),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .jtag_busy               (jtag_busy),
    .jtag_overrun            (jtag_overrun)
  );

  // RAM macro: read data one cycle after ram_en
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    ram_rdata = 32'h0;
  end
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic pulse_a(input logic [7:0] addr, input logic rd);
    jdo = '0;
    jdo[17:10] = addr;
    jdo[35] = rd;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic pulse_b(input logic [31:0] data);
    jdo = '0;
    jdo[34:3] = data;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic pulse_n();
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    jdo = '0;
    debugack = 1'b0;
    cpu_address = 8'h00;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_writedata = 32'h0;
`ifdef QSYS_NIOS2_OCIMEM_AUTOINC_EN
    exp2 = 32'hC0DE0000;
`else
    exp2 = 32'hC0DE00FF;
`endif
    tick();
    tick();
    chk1("rst_waitreq", cpu_waitrequest, 1'b1);
    chk1("rst_ram_en", ram_en, 1'b0);
    chk32("rst_mondreg", MonDReg, 32'h0);
    chk1("rst_busy", jtag_busy, 1'b0);
    chk1("rst_overrun", jtag_overrun, 1'b0);
    reset_n = 1'b1;
    tick();

    // JTAG write of 0xDEADBEEF at 0x10, then CPU read back
    pulse_a(8'h10, 1'b0);
    pulse_b(32'hDEADBEEF);
    chk1("a_busy_rise", jtag_busy, 1'b1);
    tick();
    chk1("a_ram_en", ram_en, 1'b1);
    chk1("a_ram_wr", ram_wr, 1'b1);
    chk32("a_ram_addr", 32'(ram_addr), 32'h10);
    chk32("a_ram_wdata", ram_wdata, 32'hDEADBEEF);
    tick();
    chk1("a_busy_fall", jtag_busy, 1'b0);
    cpu_read = 1'b1;
    cpu_address = 8'h10;
    tick();
    chk1("a_cpu_ram_en", ram_en, 1'b1);
    chk1("a_cpu_wait1", cpu_waitrequest, 1'b1);
    tick();
    chk1("a_cpu_wait0", cpu_waitrequest, 1'b0);
    chk32("a_cpu_rdata", cpu_readdata, 32'hDEADBEEF);
    cpu_read = 1'b0;
    tick();
    chk1("a_cpu_idle_wait", cpu_waitrequest, 1'b1);

    // Pointer at 0xFF, two back-to-back no_action reads
    pulse_a(8'hFF, 1'b0);
    pulse_n();
    pulse_n();
    chk1("b_ram_en1", ram_en, 1'b1);
    chk32("b_addr1", 32'(ram_addr), 32'hFF);
    tick();
    tick();
    chk32("b_mon1", MonDReg, 32'hC0DE00FF);
    tick();
    chk1("b_ram_en2", ram_en, 1'b1);
    chk32("b_addr2", 32'(ram_addr), 32'(exp2[7:0]));
    tick();
    tick();
    chk32("b_mon2", MonDReg, exp2);
    chk1("b_busy_done", jtag_busy, 1'b0);

    // Contention with debugack=1: JTAG first even though JTAG was granted last
    pulse_a(8'h20, 1'b0);
    debugack = 1'b1;
    pulse_b(32'h55AA55AA);
    cpu_read = 1'b1;
    cpu_address = 8'h20;
    tick();
    chk1("c_jtag_first", ram_wr, 1'b1);
    chk32("c_jtag_addr", 32'(ram_addr), 32'h20);
    chk1("c_cpu_wait_a", cpu_waitrequest, 1'b1);
    tick();
    chk1("c_cpu_wait_b", cpu_waitrequest, 1'b1);
    tick();
    chk1("c_cpu_ram_en", ram_en, 1'b1);
    chk1("c_cpu_ram_rd", ram_wr, 1'b0);
    tick();
    chk1("c_cpu_wait0", cpu_waitrequest, 1'b0);
    chk32("c_cpu_rdata", cpu_readdata, 32'h55AA55AA);
    cpu_read = 1'b0;
    debugack = 1'b0;
    tick();

    // Contention with debugack=0 after a JTAG grant: CPU first
    pulse_a(8'h30, 1'b0);
    pulse_b(32'h01010101);
    tick();
    tick();
    pulse_b(32'h02020202);
    cpu_write = 1'b1;
    cpu_address = 8'h40;
    cpu_writedata = 32'h77777777;
    tick();
    chk1("d_cpu_first_wait", cpu_waitrequest, 1'b0);
    chk32("d_cpu_addr", 32'(ram_addr), 32'h40);
    chk32("d_cpu_wdata", ram_wdata, 32'h77777777);
    chk1("d_jtag_pending", jtag_busy, 1'b1);
    cpu_write = 1'b0;
    tick();
    chk1("d_idle_wait", cpu_waitrequest, 1'b1);
    tick();
    chk1("d_jtag_en", ram_en, 1'b1);
    chk32("d_jtag_wdata", ram_wdata, 32'h02020202);
    tick();

    // CPU write 0x12345678 at 0x80
    cpu_write = 1'b1;
    cpu_address = 8'h80;
    cpu_writedata = 32'h12345678;
    tick();
    chk1("f_wait0", cpu_waitrequest, 1'b0);
    chk1("f_ram_wr", ram_wr, 1'b1);
    chk32("f_ram_addr", 32'(ram_addr), 32'h80);
    chk32("f_ram_wdata", ram_wdata, 32'h12345678);
    cpu_write = 1'b0;
    tick();
    chk1("f_wait1", cpu_waitrequest, 1'b1);

    // Three consecutive JTAG pulses: third dropped
    pulse_n();
    pulse_b(32'hA1A2A3A4);
    chk1("e_first_rd", ram_wr, 1'b0);
    chk1("e_first_en", ram_en, 1'b1);
    pulse_n();
    chk1("e_overrun", jtag_overrun, 1'b1);
    tick();
    tick();
    chk1("e_second_wr", ram_wr, 1'b1);
    chk32("e_second_data", ram_wdata, 32'hA1A2A3A4);
    tick();
    chk1("e_busy_done", jtag_busy, 1'b0);
    chk1("e_overrun_sticky", jtag_overrun, 1'b1);
    tick();

    // Reset in the middle of a CPU read
    cpu_read = 1'b1;
    cpu_address = 8'h10;
    tick();
    tick();
    chk1("g_in_rdw", cpu_waitrequest, 1'b0);
    reset_n = 1'b0;
    cpu_read = 1'b0;
    tick();
    chk1("g_wait", cpu_waitrequest, 1'b1);
    chk1("g_ram_en", ram_en, 1'b0);
    chk1("g_ram_wr", ram_wr, 1'b0);
    chk32("g_ram_addr", 32'(ram_addr), 32'h0);
    chk32("g_ram_wdata", ram_wdata, 32'h0);
    chk32("g_rdata", cpu_readdata, 32'h0);
    chk32("g_mondreg", MonDReg, 32'h0);
    chk1("g_busy", jtag_busy, 1'b0);
    chk1("g_overrun", jtag_overrun, 1'b0);
    reset_n = 1'b1;
    tick();
    pulse_n();
    tick();
    chk1("g_ptr_en", ram_en, 1'b1);
    chk32("g_ptr_zero", 32'(ram_addr), 32'h0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qsys_system_nios2_1_cpu_ocimem_arbiter.md
# qsys_system_nios2_1_cpu_ocimem_arbiter

Sequences and arbitrates the Nios II on-chip debug memory (OCI RAM, 256 x 32) between two requesters: the JTAG debug-slave command path (take_action/take_no_action pulses with jdo, sysclk domain) and the CPU's Avalon debug-memory slave port. It owns the single RAM port, the JTAG address pointer and the MonDReg readback register. It sits in the sysclk domain between the debug-slave sysclk stage and the OCI RAM macro.

## Interface
- No parameters; RAM is fixed at 8-bit address, 32-bit data, 1-cycle read latency.
- clk  in  1  system clock, all logic rising-edge
- reset_n  in  1  reset; one clock; reset is synchronous and active-low
- take_action_ocimem_a  in  1  JTAG pulse: load address pointer from jdo[17:10]; read there if jdo[35]=1
- take_action_ocimem_b  in  1  JTAG pulse: write jdo[34:3] at pointer
- take_no_action_ocimem_a  in  1  JTAG pulse: read at pointer
- jdo  in  38  JTAG data, valid on pulse cycle only
- debugack  in  1  CPU halted in debug mode
- cpu_address  in  8  Avalon word address
- cpu_read / cpu_write  in  1  Avalon strobes, held until waitrequest low
- cpu_writedata  in  32  Avalon write data
- cpu_readdata  out  32  Avalon read data, valid when waitrequest low on a read
- cpu_waitrequest  out  1  Avalon stall
- ram_en / ram_wr  out  1  RAM access enable / write enable (registered)
- ram_addr  out  8; ram_wdata  out  32 (registered)
- ram_rdata  in  32  RAM data, valid one cycle after ram_en
- MonDReg  out  32  last JTAG read data
- jtag_busy  out  1  JTAG request pending or in flight
- jtag_overrun  out  1  sticky: JTAG pulse dropped

## Operation
- FSM states: IDLE, JTAG_ACC, JTAG_RDW, CPU_ACC, CPU_RDW.
- JTAG pulses latch into a 1-deep pending slot {op, addr, data}. ocimem_a with jdo[35]=0 updates the pointer immediately, creates no RAM access.
- Pulse arriving while slot full or JTAG access in flight: dropped, jtag_overrun set; cleared only by reset.
- Arbitration in IDLE: if both pending, JTAG wins when debugack=1; otherwise round-robin, the last-granted side loses. Single requester granted immediately.
- JTAG_ACC: ram_en=1 for one cycle; write -> IDLE; read -> JTAG_RDW, which loads MonDReg <= ram_rdata, -> IDLE.
- CPU_ACC: ram_en=1; write completes here (cpu_waitrequest=0) -> IDLE; read -> CPU_RDW: cpu_readdata=ram_rdata, cpu_waitrequest=0 -> IDLE.
- cpu_waitrequest=1 in all other cycles, including idle.
- Pointer arithmetic: 8-bit, wraps 0xFF -> 0x00.
- Reset (any state, mid-access included): state IDLE, slot empty, pointer 0, MonDReg 0, cpu_readdata 0, ram_en/ram_wr 0, ram_addr/ram_wdata 0, cpu_waitrequest 1, jtag_busy 0, jtag_overrun 0; an in-flight CPU access is abandoned, and the master must re-issue it.

## Timing
- Request visible in IDLE at cycle N -> ram_en high in N+1.
- CPU write: waitrequest low in N+1. CPU read: waitrequest low in N+2, data valid then.
- JTAG read: MonDReg updated at the end of N+2 and visible from N+3.
- A losing requester waits at most one full access: 3 cycles after a read, 2 after a write.
- Pulse in the same cycle the slot drains: the slot accepts it with no overrun.
- jtag_busy rises the cycle after the pulse and falls the cycle after access completion.

## Configuration
- QSYS_NIOS2_OCIMEM_AUTOINC_EN defined: pointer increments by 1 (with wrap) after each ocimem_b write and each no_action_ocimem_a read. A jdo[35] read does not increment.
- Undefined: pointer changes only on ocimem_a.

## Test plan
- Reset mid CPU read (in CPU_RDW) -> next cycle all outputs at reset values, cpu_waitrequest=1, pointer 0.
- ocimem_a jdo[17:10]=0x10, then ocimem_b data 0xDEADBEEF, then CPU read 0x10 -> ram write at 0x10; cpu_readdata=0xDEADBEEF with waitrequest low 2 cycles after grant.
- With AUTOINC_EN: pointer 0xFF, two no_action reads -> RAM reads at 0xFF then 0x00, MonDReg tracks each. Without the macro: both reads at 0xFF.
- CPU read held and JTAG write pulsed in the same cycle: debugack=1 -> JTAG granted first, CPU completes 2 cycles later. debugack=0, last grant JTAG -> CPU first.
- Three JTAG pulses on consecutive cycles -> third dropped, jtag_overrun=1 and sticky, first two accesses complete.
- CPU write to 0x80 of 0x12345678 -> waitrequest low exactly 1 cycle after request, ram_wr=1 with ram_addr=0x80.
